// File: rtl/ccta_if.sv
// ccta_if: operand/result bundle for the ccta compare-and-add stage.
//   A, B, C : W-bit unsigned operands        (master -> slave)
//   ctrl    : 0 = sum of two largest, 1 = sum of two smallest (master -> slave)
//   q       : W+1-bit registered result       (slave -> master)
interface ccta_if #(
    parameter int W = 4
);
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] C;
    logic         ctrl;
    logic [W:0]   q;

    modport master (
        output A, B, C, ctrl,
        input  q
    );

    modport slave (
        input  A, B, C, ctrl,
        output q
    );
endinterface

// File: rtl/ccta.sv
// ccta: sorts three unsigned operands and adds either the two largest
// (ctrl=0) or the two smallest (ctrl=1), producing a registered W+1-bit sum.
//
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, clears every register
//   bus : ccta_if.slave carrying A, B, C, ctrl in and q out
//
// Build option:
//   CCTA_PIPE_EN defined   -> register stage between sort and add (latency 2)
//   CCTA_PIPE_EN undefined -> output register only (latency 1)
module ccta #(
    parameter int W = 4
) (
    input  logic    clk,
    input  logic    rst,
    ccta_if.slave   bus
);

    logic [W-1:0] hi_ab, lo_ab;
    logic [W-1:0] max_c, mid_c, min_c;

    // Two-step sort: order A/B, then slot C into the pair.
    // Ties resolve arbitrarily; the sum does not depend on which tied
    // operand lands in which rank.
    always_comb begin
        hi_ab = bus.A;
        lo_ab = bus.B;
        if (bus.A < bus.B) begin
            hi_ab = bus.B;
            lo_ab = bus.A;
        end

        max_c = hi_ab;
        mid_c = lo_ab;
        min_c = bus.C;
        if (bus.C >= hi_ab) begin
            max_c = bus.C;
            mid_c = hi_ab;
            min_c = lo_ab;
        end else if (bus.C >= lo_ab) begin
            mid_c = bus.C;
            min_c = lo_ab;
        end
    end

    logic [W-1:0] add_max, add_mid, add_min;
    logic         add_ctrl;

`ifdef CCTA_PIPE_EN
    logic [W-1:0] max_q, mid_q, min_q;
    logic         ctrl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            max_q  <= '0;
            mid_q  <= '0;
            min_q  <= '0;
            ctrl_q <= 1'b0;
        end else begin
            max_q  <= max_c;
            mid_q  <= mid_c;
            min_q  <= min_c;
            ctrl_q <= bus.ctrl;
        end
    end

    assign add_max  = max_q;
    assign add_mid  = mid_q;
    assign add_min  = min_q;
    assign add_ctrl = ctrl_q;
`else
    assign add_max  = max_c;
    assign add_mid  = mid_c;
    assign add_min  = min_c;
    assign add_ctrl = bus.ctrl;
`endif

    logic [W:0] q_d, q_q;

    // Zero-extend before adding so the carry lands in the top bit.
    always_comb begin
        if (add_ctrl) q_d = {1'b0, add_min} + {1'b0, add_mid};
        else          q_d = {1'b0, add_max} + {1'b0, add_mid};
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign bus.q = q_q;

endmodule

// File: tb/tb_ccta.sv
module tb_ccta;

`ifdef CCTA_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    ccta_if #(.W(4)) bus ();

    ccta #(.W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Expected q values in flight; entry LAT-1 is what q must show after an edge.
    logic [4:0] exp_pipe [LAT];

    // Reference: drop the excluded extreme from the total of all three.
    function automatic logic [4:0] ref_sum(input int a, input int b, input int c,
                                           input logic mode);
        int total, mx, mn;
        total = a + b + c;
        mx = a; if (b > mx) mx = b; if (c > mx) mx = c;
        mn = a; if (b < mn) mn = b; if (c < mn) mn = c;
        return mode ? 5'(total - mx) : 5'(total - mn);
    endfunction

    task automatic step(input string tag, input int a, input int b, input int c,
                        input logic mode, input logic r);
        bus.A    = 4'(a);
        bus.B    = 4'(b);
        bus.C    = 4'(c);
        bus.ctrl = mode;
        rst      = r;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < LAT; i++) exp_pipe[i] = 5'h00;
        end else begin
            for (int i = LAT - 1; i > 0; i--) exp_pipe[i] = exp_pipe[i-1];
            exp_pipe[0] = ref_sum(a, b, c, mode);
        end
        #1;
        vectors++;
        assert (bus.q === exp_pipe[LAT-1]) else begin
            miscompares++;
            $error("FAIL %s: q=%h expected %h", tag, bus.q, exp_pipe[LAT-1]);
        end
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) exp_pipe[i] = 5'h00;
        bus.A = 4'h4; bus.B = 4'h1; bus.C = 4'h9; bus.ctrl = 1'b0;

        // Reset held two edges, then release; result flows out after LAT.
        step("rst0", 4, 1, 9, 1'b0, 1'b1);
        step("rst1", 4, 1, 9, 1'b0, 1'b1);

        // Two-largest
        step("max0", 4'h4, 4'h1, 4'h9, 1'b0, 1'b0);
        step("max1", 4'h3, 4'hD, 4'hD, 1'b0, 1'b0);
        step("max2", 4'h5, 4'h2, 4'h1, 1'b0, 1'b0);
        step("max3", 4'hD, 4'h6, 4'hD, 1'b0, 1'b0);
        step("max4", 4'hD, 4'hC, 4'h9, 1'b0, 1'b0);

        // Two-smallest, with a one-cycle reset in the middle
        step("min0", 4'h6, 4'h5, 4'hA, 1'b1, 1'b0);
        step("min1", 4'h5, 4'h7, 4'h2, 1'b1, 1'b0);
        step("min2", 4'hF, 4'h2, 4'hE, 1'b1, 1'b0);
        step("midrst", 4'h8, 4'h5, 4'hC, 1'b1, 1'b1);
        step("min3", 4'h8, 4'h5, 4'hC, 1'b1, 1'b0);
        step("min4", 4'hD, 4'hD, 4'h5, 1'b1, 1'b0);
        step("min5", 4'h3, 4'hA, 4'h0, 1'b1, 1'b0);

        // Extremes
        step("ext0", 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
        step("ext1", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        step("ext2", 4'hF, 4'hF, 4'h0, 1'b1, 1'b0);

        // Mode toggle, same operands, back to back
        step("tog0", 4'h6, 4'h5, 4'hA, 1'b0, 1'b0);
        step("tog1", 4'h6, 4'h5, 4'hA, 1'b1, 1'b0);

        // Drain directed results so fixed values are checked explicitly too
        for (int i = 0; i < LAT; i++) step("drain", 4'h6, 4'h5, 4'hA, 1'b1, 1'b0);

        // Randomized stream with occasional resets
        for (int n = 0; n < 400; n++) begin
            step("rand", int'($urandom_range(15)), int'($urandom_range(15)),
                 int'($urandom_range(15)), 1'($urandom_range(1)),
                 ($urandom_range(19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Fixed-value spot checks on the directed stream, independent of the model.
    initial begin : spot
        logic [4:0] want [$];
        int         cyc;
        // q after each directed edge for LAT=1; for LAT=2 shift by one cycle.
        want = '{5'h00, 5'h00, 5'h0D, 5'h1A, 5'h07, 5'h1A, 5'h19,
                 5'h0B, 5'h07, 5'h10, 5'h00, 5'h0D, 5'h12, 5'h03,
                 5'h1E, 5'h00, 5'h0F, 5'h10, 5'h0B};
        if (LAT == 2) begin
            // extra cycle: first result one edge later, and the mid-stream
            // reset also swallows the sample that was in the sort stage
            want = '{5'h00, 5'h00, 5'h00, 5'h0D, 5'h1A, 5'h07, 5'h1A, 5'h19,
                     5'h0B, 5'h07, 5'h00, 5'h00, 5'h0D, 5'h12, 5'h03,
                     5'h1E, 5'h00, 5'h0F, 5'h10, 5'h0B};
        end
        cyc = 0;
        while (cyc < want.size()) begin
            @(posedge clk);
            #2;
            vectors++;
            assert (bus.q === want[cyc]) else begin
                miscompares++;
                $error("FAIL spot%0d: q=%h expected %h", cyc, bus.q, want[cyc]);
            end
            cyc++;
        end
    end

endmodule
